// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed, active-low 7-segment scan bus.
// Each digit commits only after a pattern has been seen STABLE_CYCLES times in a row.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [6:0]              seven_seg_display,
   input  logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [4*NUM_DIGITS-1:0] hex_value,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, COUNTING, COMMITTED} state_t;

   state_t          state;
   logic [IW-1:0]   last_digit;
   logic [6:0]      last_pattern;
   logic [CW-1:0]   count;

   logic            qualified;
   logic [3:0]      ones;
   logic [IW-1:0]   sel_index;
   logic            pat_ok;
   logic [3:0]      pat_nibble;
   logic            same_pair;
   logic            commit;
   logic [3:0]      held_nibble;
   logic            change_event;

   always_comb begin
      ones      = '0;
      sel_index = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_sel[i]) begin
            ones      = ones + 4'd1;
            sel_index = IW'(i);
         end
      end
      qualified = (ones == 4'd1);

      pat_ok     = 1'b1;
      pat_nibble = 4'h0;
      case (seven_seg_display)
         7'b1000000: pat_nibble = 4'h0;
         7'b1111001: pat_nibble = 4'h1;
         7'b0100100: pat_nibble = 4'h2;
         7'b0110000: pat_nibble = 4'h3;
         7'b0011001: pat_nibble = 4'h4;
         7'b0010010: pat_nibble = 4'h5;
         7'b0000010: pat_nibble = 4'h6;
         7'b1111000: pat_nibble = 4'h7;
         7'b0000000: pat_nibble = 4'h8;
         7'b0010000: pat_nibble = 4'h9;
         7'b0001000: pat_nibble = 4'hA;
         7'b0000011: pat_nibble = 4'hB;
         7'b1000110: pat_nibble = 4'hC;
         7'b0100001: pat_nibble = 4'hD;
         7'b0000110: pat_nibble = 4'hE;
         7'b0001110: pat_nibble = 4'hF;
         default:    pat_ok     = 1'b0;
      endcase

      same_pair    = (state != IDLE) && (sel_index == last_digit) &&
                     (seven_seg_display == last_pattern);
      // The sample that brings the run length up to STABLE_CYCLES is the commit sample.
      commit       = qualified && (state == COUNTING) && same_pair &&
                     (count == CW'(STABLE_CYCLES - 1));
      held_nibble  = hex_value[4*int'(sel_index) +: 4];
      change_event = commit && pat_ok &&
                     (!digit_valid[sel_index] || (held_nibble != pat_nibble));
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         last_digit   <= '0;
         last_pattern <= '0;
         count        <= '0;
         hex_value    <= '0;
         digit_valid  <= '0;
         digit_err    <= '0;
         out_valid    <= 1'b0;
      end else begin
         if (!qualified) begin
            state <= IDLE;
            count <= '0;
         end else if (!same_pair) begin
            state        <= COUNTING;
            last_digit   <= sel_index;
            last_pattern <= seven_seg_display;
            count        <= CW'(1);
         end else if (state == COUNTING) begin
            count <= count + CW'(1);
            if (commit) begin
               state <= COMMITTED;
            end
         end

         if (commit) begin
            if (pat_ok) begin
               hex_value[4*int'(sel_index) +: 4] <= pat_nibble;
               digit_valid[sel_index]            <= 1'b1;
               digit_err[sel_index]              <= 1'b0;
            end else begin
               digit_err[sel_index] <= 1'b1;
            end
         end

         // A new change wins over a simultaneous handshake so no update is lost.
         if (change_event) begin
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a run-length reference model queues the
// expected output state per clock and a negedge monitor compares it against the DUT.
module tb_seg7_scan_decoder;

   localparam int NUM_DIGITS    = 4;
   localparam int STABLE_CYCLES = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [6:0]  seven_seg_display = 7'h7F;
   logic [3:0]  digit_sel = 4'b0000;
   logic [15:0] hex_value;
   logic [3:0]  digit_valid;
   logic [3:0]  digit_err;
   logic        out_valid;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   seg7_scan_decoder #(
      .NUM_DIGITS(NUM_DIGITS),
      .STABLE_CYCLES(STABLE_CYCLES)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .seven_seg_display(seven_seg_display),
      .digit_sel(digit_sel),
      .hex_value(hex_value),
      .digit_valid(digit_valid),
      .digit_err(digit_err),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   typedef struct packed {
      logic [15:0] hex;
      logic [3:0]  valid;
      logic [3:0]  err;
      logic        ov;
   } snap_t;

   snap_t exp_q[$];
   int checks = 0;
   int failures = 0;

   logic [6:0] seg_table [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic [3:0] m_hex [4];
   logic [3:0] m_valid;
   logic [3:0] m_err;
   logic       m_ov;
   int         run_len;
   int         prev_digit;
   logic [6:0] prev_pat;

   function automatic int decode(input logic [6:0] p);
      for (int i = 0; i < 16; i++) begin
         if (seg_table[i] == p) return i;
      end
      return -1;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: got %h, required %h at %0t", name, actual, required, $time);
      end
   endtask

   // Reference: a digit commits when the run of identical qualified samples hits STABLE_CYCLES.
   task automatic model_step(input logic rstn, input logic [3:0] sel, input logic [6:0] pat, input logic rdy);
      snap_t s;
      int d;
      int nib;
      logic change;
      change = 1'b0;
      if (!rstn) begin
         for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
         m_valid = '0;
         m_err   = '0;
         m_ov    = 1'b0;
         run_len = 0;
      end else begin
         if ($countones(sel) != 1) begin
            run_len = 0;
         end else begin
            d = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) d = i;
            if (run_len > 0 && d == prev_digit && pat == prev_pat) begin
               run_len++;
            end else begin
               run_len    = 1;
               prev_digit = d;
               prev_pat   = pat;
            end
            if (run_len == STABLE_CYCLES) begin
               nib = decode(pat);
               if (nib < 0) begin
                  m_err[d] = 1'b1;
               end else begin
                  change     = !m_valid[d] || (m_hex[d] != nib[3:0]);
                  m_hex[d]   = nib[3:0];
                  m_valid[d] = 1'b1;
                  m_err[d]   = 1'b0;
               end
            end
         end
         if (change) m_ov = 1'b1;
         else if (m_ov && rdy) m_ov = 1'b0;
      end
      s.hex   = {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
      s.valid = m_valid;
      s.err   = m_err;
      s.ov    = m_ov;
      exp_q.push_back(s);
   endtask

   task automatic apply_stimulus(input logic rstn, input logic [3:0] sel, input logic [6:0] pat, input logic rdy);
      resetn            = rstn;
      digit_sel         = sel;
      seven_seg_display = pat;
      out_ready         = rdy;
      @(posedge clk);
      model_step(rstn, sel, pat, rdy);
      #1;
   endtask

   always @(negedge clk) begin
      snap_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_output("hex_value", 32'(hex_value), 32'(e.hex));
         check_output("digit_valid", 32'(digit_valid), 32'(e.valid));
         check_output("digit_err", 32'(digit_err), 32'(e.err));
         check_output("out_valid", 32'(out_valid), 32'(e.ov));
      end
   end

   initial begin
      logic [3:0] sel;
      logic [6:0] pat;
      int len;

      for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
      m_valid = '0; m_err = '0; m_ov = 1'b0;
      run_len = 0; prev_digit = 0; prev_pat = '0;

      repeat (2) apply_stimulus(1'b0, 4'b0000, 7'h7F, 1'b0);
      check_output("reset_hex", 32'(hex_value), 32'h0);
      check_output("reset_out_valid", 32'(out_valid), 32'h0);

      repeat (4) apply_stimulus(1'b1, 4'b0001, 7'b0100100, 1'b0);
      check_output("d0_is_2", 32'(hex_value[3:0]), 32'h2);
      check_output("d0_valid", 32'(digit_valid), 32'h1);
      check_output("first_change_ov", 32'(out_valid), 32'h1);
      apply_stimulus(1'b1, 4'b0000, 7'h7F, 1'b1);
      check_output("handshake_clears", 32'(out_valid), 32'h0);

      repeat (3) apply_stimulus(1'b1, 4'b0010, 7'b0100100, 1'b0);
      check_output("no_early_commit", 32'(digit_valid), 32'h1);
      repeat (4) apply_stimulus(1'b1, 4'b0010, 7'b0110000, 1'b0);
      check_output("d1_is_3", 32'(hex_value[7:4]), 32'h3);

      repeat (4) apply_stimulus(1'b1, 4'b0100, 7'b1111111, 1'b0);
      check_output("d2_err", 32'(digit_err), 32'h4);
      check_output("d2_not_valid", 32'(digit_valid[2]), 32'h0);
      check_output("err_keeps_ov", 32'(out_valid), 32'h1);
      apply_stimulus(1'b1, 4'b0000, 7'h7F, 1'b1);

      repeat (4) apply_stimulus(1'b1, 4'b0001, 7'b0010010, 1'b0);
      repeat (4) apply_stimulus(1'b1, 4'b0010, 7'b0010000, 1'b0);
      check_output("coalesced_ov", 32'(out_valid), 32'h1);
      apply_stimulus(1'b1, 4'b0000, 7'h7F, 1'b1);
      check_output("coalesced_cleared", 32'(out_valid), 32'h0);
      check_output("hex_95", 32'(hex_value[7:0]), 32'h95);

      repeat (10) apply_stimulus(1'b1, 4'b0011, 7'b0000000, 1'b0);
      check_output("multihot_ignored", 32'(digit_valid), 32'h3);
      repeat (3) apply_stimulus(1'b1, 4'b1000, 7'b0000000, 1'b1);
      apply_stimulus(1'b0, 4'b1000, 7'b0000000, 1'b0);
      check_output("midcount_reset_hex", 32'(hex_value), 32'h0);
      check_output("midcount_reset_valid", 32'(digit_valid), 32'h0);
      repeat (3) apply_stimulus(1'b1, 4'b1000, 7'b0000000, 1'b0);
      check_output("restart_no_commit", 32'(digit_valid), 32'h0);
      apply_stimulus(1'b1, 4'b1000, 7'b0000000, 1'b0);
      check_output("restart_commit", 32'(hex_value[15:12]), 32'h8);

      for (int b = 0; b < 400; b++) begin
         case ($urandom_range(0, 9))
            0:       sel = 4'($urandom_range(0, 15));
            default: sel = 4'b0001 << $urandom_range(0, 3);
         endcase
         if ($urandom_range(0, 4) == 0) pat = 7'($urandom_range(0, 127));
         else pat = seg_table[$urandom_range(0, 15)];
         len = $urandom_range(1, 7);
         for (int k = 0; k < len; k++) begin
            apply_stimulus(($urandom_range(0, 99) != 0), sel, pat, 1'($urandom_range(0, 1)));
         end
      end

      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
      #1;
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of scanned digit positions (1..8).
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical samples required before commit (2..255).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 seven_seg_display  input  7  active-low segment pattern, bit0=a ... bit6=g.
REQ-006 digit_sel  input  NUM_DIGITS  one-hot strobe naming the digit the current pattern belongs to.
REQ-007 hex_value  output  4*NUM_DIGITS  decoded nibble per digit, digit d at bits [4d+3:4d].
REQ-008 digit_valid  output  NUM_DIGITS  digit d holds a decoded value.
REQ-009 digit_err  output  NUM_DIGITS  last commit for digit d was an unrecognised pattern.
REQ-010 out_valid  output  1  hex_value changed since last accepted handshake.
REQ-011 out_ready  input  1  consumer acknowledges the change notification.

Function
REQ-012 Decode table (pattern -> nibble): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F; all other 112 patterns are invalid.
REQ-013 Sample qualified only when digit_sel has exactly one bit set; zero or multi-hot digit_sel -> sample ignored, filter returns to IDLE.
REQ-014 Filter registers: last digit index, last pattern, stability counter (width ceil(log2(STABLE_CYCLES+1))).
REQ-015 States: IDLE (no tracked sample), COUNTING (tracking digit/pattern pair), COMMITTED (pair already committed).
REQ-016 IDLE + qualified sample -> COUNTING, capture pair, counter=1.
REQ-017 COUNTING + qualified sample equal to tracked pair -> counter+1; when counter reaches STABLE_CYCLES on that sample, commit in same cycle (results visible next cycle) and go to COMMITTED.
REQ-018 COUNTING or COMMITTED + qualified sample with different digit or pattern -> COUNTING, capture new pair, counter=1.
REQ-019 COMMITTED + identical qualified sample -> stay COMMITTED, no further commit, counter saturates.
REQ-020 Commit, valid pattern: hex_value[d]=nibble, digit_valid[d]=1, digit_err[d]=0.
REQ-021 Commit, invalid pattern: digit_err[d]=1; hex_value[d] and digit_valid[d] unchanged.
REQ-022 Change event: valid commit where digit_valid[d] was 0 or nibble differs from held hex_value[d]; invalid commits and same-value commits are not change events.
REQ-023 out_valid set cycle after a change event; cleared cycle after out_valid=1 and out_ready=1; simultaneous change event and handshake -> out_valid stays 1.
REQ-024 Multiple change events while out_valid=1 coalesce into one pending notification; hex_value always shows latest state.
REQ-025 Latency: commit outputs change exactly STABLE_CYCLES cycles after first sample of a stable run (sample cycle counts as 1).
REQ-026 Only one digit commits per cycle; no other digit's registers are affected.

Reset
REQ-027 resetn=0 on clock edge: hex_value=0, digit_valid=0, digit_err=0, out_valid=0, filter IDLE, counter=0.
REQ-028 Reset mid-count or with out_valid pending discards all progress and pending notification; first sample after release starts a new run at counter=1.
REQ-029 Inputs ignored during the reset cycle.

Verification
REQ-030 digit_sel=0001, pattern 0100100 held 4 cycles -> 4 cycles later hex_value[3:0]=2, digit_valid=0001, out_valid=1.
REQ-031 digit_sel=0010, pattern 0100100 for 3 cycles then 0110000 for 4 -> no commit of 2; hex_value[7:4]=3 after the 4th 0110000 sample.
REQ-032 digit_sel=0100, pattern 1111111 held 4 cycles -> digit_err=0100, digit_valid[2]=0, out_valid unchanged.
REQ-033 out_ready=0, commits 5 on digit0 then 9 on digit1 -> single out_valid pulse held high; out_ready=1 one cycle -> out_valid=0 next cycle, hex_value[7:0]=8'h95.
REQ-034 digit_sel=0011 for 10 cycles -> no commit, filter IDLE; resetn=0 at counter=3 -> no commit, all outputs 0.
